// File: rtl/fifo_axi_write_drain.sv
// ============================================================================
// Module   : fifo_axi_write_drain
// Brief    : AXI4 write master draining a show-ahead FIFO into INCR bursts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_axi_write_drain #(
    parameter int         MAX_BURST = 16,
    parameter logic [3:0] AXI_ID    = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_cnt,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [31:0] fifo_do,
    input  logic        fifo_empty,
    output logic        fifo_ren,
    output logic [3:0]  AWID,
    output logic [31:0] AWADDR,
    output logic [3:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [3:0]  BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY
);

    localparam logic [4:0] c_max_burst = 5'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic [15:0] r_remaining;
    logic [3:0]  r_awlen;
    logic [3:0]  r_beat;
    logic        r_err;

    logic [31:0] w_src_addr;
    logic [15:0] w_src_rem;
    logic [4:0]  w_len_cur;
    logic [10:0] w_room;
    logic [4:0]  w_len;
    logic        w_last;
    logic        w_w_hs;
    logic        w_bresp_ok;
    logic        w_unused_bid;

    assign w_unused_bid = ^BID;

    // The next burst is sized from the values it will start from: the
    // programmed inputs when leaving IDLE, the advanced pointer after a B.
    assign w_len_cur  = {1'b0, r_awlen} + 5'd1;
    assign w_src_addr = (r_state == S_IDLE) ? {base_addr[31:2], 2'b00}
                                            : r_addr + {25'd0, w_len_cur, 2'b00};
    assign w_src_rem  = (r_state == S_IDLE) ? word_cnt
                                            : r_remaining - {11'd0, w_len_cur};
    assign w_room     = 11'((13'h1000 - {1'b0, w_src_addr[11:0]}) >> 2);

    always_comb begin
        w_len = c_max_burst;
        if (w_src_rem < {11'd0, w_len})
            w_len = w_src_rem[4:0];
        if ({5'd0, w_room} < {11'd0, w_len})
            w_len = w_room[4:0];
    end

    assign w_last     = (r_beat == r_awlen);
    assign w_w_hs     = WVALID && WREADY;
    assign w_bresp_ok = (BRESP == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_state_nxt = (word_cnt == 16'd0) ? S_DONE : S_AW;
            end
            S_AW: begin
                if (AWREADY)
                    w_state_nxt = S_W;
            end
            S_W: begin
                if (w_w_hs && w_last)
                    w_state_nxt = S_B;
            end
            S_B: begin
                if (BVALID)
                    w_state_nxt = (!w_bresp_ok || w_src_rem == 16'd0) ? S_DONE : S_AW;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= 32'd0;
            r_remaining <= 16'd0;
            r_awlen     <= 4'd0;
            r_beat      <= 4'd0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= w_src_addr;
                        r_remaining <= w_src_rem;
                        r_err       <= 1'b0;
                        if (word_cnt != 16'd0)
                            r_awlen <= 4'(w_len - 5'd1);
                    end
                end
                S_AW: begin
                    if (AWREADY)
                        r_beat <= 4'd0;
                end
                S_W: begin
                    if (w_w_hs)
                        r_beat <= r_beat + 4'd1;
                end
                S_B: begin
                    if (BVALID) begin
                        if (!w_bresp_ok) begin
                            r_err <= 1'b1;
                        end else begin
                            r_addr      <= w_src_addr;
                            r_remaining <= w_src_rem;
                            if (w_src_rem != 16'd0)
                                r_awlen <= 4'(w_len - 5'd1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign err      = r_err;
    assign AWID     = AXI_ID;
    assign AWADDR   = r_addr;
    assign AWLEN    = r_awlen;
    assign AWSIZE   = 3'b010;
    assign AWBURST  = 2'b01;
    assign AWVALID  = (r_state == S_AW);
    assign WDATA    = fifo_do;
    assign WSTRB    = 4'hF;
    assign WVALID   = (r_state == S_W) && !fifo_empty;
    assign WLAST    = WVALID && w_last;
    assign fifo_ren = w_w_hs;
    assign BREADY   = (r_state == S_B);

endmodule

`default_nettype wire

// File: tb/tb_fifo_axi_write_drain.sv
// ============================================================================
// Module   : tb_fifo_axi_write_drain
// Brief    : Self-checking bench with FIFO/AXI-slave models and a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_axi_write_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_cnt;
    logic        busy, done, err;
    logic [31:0] fifo_do;
    logic        fifo_empty;
    logic        fifo_ren;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST, WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP = 2'b00;
    logic        BVALID = 1'b0;
    logic        BREADY;

    always #5 clk = ~clk;

    fifo_axi_write_drain #(.MAX_BURST(16), .AXI_ID(4'h0)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_cnt(word_cnt), .busy(busy), .done(done), .err(err),
        .fifo_do(fifo_do), .fifo_empty(fifo_empty), .fifo_ren(fifo_ren),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY), .BID(BID), .BRESP(BRESP), .BVALID(BVALID),
        .BREADY(BREADY)
    );

    typedef struct { logic [31:0] addr; logic [3:0] len; } aw_t;
    typedef struct { logic [31:0] data; logic last; } w_t;
    typedef struct {
        logic [31:0] base;
        logic [15:0] cnt;
        logic [31:0] dbase;
        int          err_burst;
        int          exp_bursts;
        int          exp_pops;
        logic        exp_err;
        logic        poke;
    } vec_t;

    aw_t        aw_exp[$];
    w_t         w_exp[$];
    logic [1:0] bresp_q[$];

    // FIFO model: bench writes at wr_ptr, the slave process pops at rd_ptr
    logic [31:0] mem [256];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_do    = mem[rd_ptr];
    assign BID        = 4'h0;

    int checks   = 0;
    int errors   = 0;
    int pop_cnt  = 0;
    int done_cnt = 0;
    int aw_cnt   = 0;
    logic s_pop = 1'b0, s_bset = 1'b0, s_bclr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference burst split: min(remaining, 16, words to the 4KB boundary)
    task automatic build_model(input logic [31:0] base, input logic [15:0] cnt,
                               input logic [31:0] dbase, input int err_burst);
        logic [31:0] a;
        int rem, len, room, k, idx;
        aw_t e;
        w_t  w;
        a = {base[31:2], 2'b00};
        rem = int'(cnt);
        k = 0;
        idx = 0;
        while (rem > 0) begin
            room = (4096 - int'({20'd0, a[11:0]})) / 4;
            len = rem;
            if (len > 16) len = 16;
            if (len > room) len = room;
            e.addr = a;
            e.len  = 4'(len - 1);
            aw_exp.push_back(e);
            for (int j = 0; j < len; j++) begin
                w.data = dbase + 32'(k);
                w.last = (j == len - 1);
                w_exp.push_back(w);
                k++;
            end
            bresp_q.push_back((idx == err_burst) ? 2'b10 : 2'b00);
            if (idx == err_burst) break;
            idx++;
            rem -= len;
            a = a + 32'(len * 4);
        end
    endtask

    task automatic fifo_fill(input logic [31:0] dbase, input int n);
        for (int k = 0; k < n; k++) begin
            mem[wr_ptr] = dbase + 32'(k);
            wr_ptr = wr_ptr + 8'd1;
        end
    endtask

    task automatic start_xfer(input logic [31:0] b, input logic [15:0] c);
        base_addr = b;
        word_cnt  = c;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL done_timeout: no done pulse within %0d cycles", max_cyc);
        end
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        int p0, d0, a0;
        wr_ptr = rd_ptr;
        fifo_fill(v.dbase, int'(v.cnt));
        build_model(v.base, v.cnt, v.dbase, v.err_burst);
        p0 = pop_cnt;
        d0 = done_cnt;
        a0 = aw_cnt;
        start_xfer(v.base, v.cnt);
        if (v.poke) begin
            repeat (3) tick();
            start_xfer(32'h0000_5000, 16'd3);
        end
        wait_done(2000, d0);
        chk("aw_count",   32'(aw_cnt - a0),   32'(v.exp_bursts));
        chk("pop_count",  32'(pop_cnt - p0),  32'(v.exp_pops));
        chk("done_count", 32'(done_cnt - d0), 32'd1);
        chk("err_end",    err,  v.exp_err);
        chk("busy_end",   busy, 1'b0);
        chk("aw_left",    32'(aw_exp.size()), 32'd0);
        chk("w_left",     32'(w_exp.size()),  32'd0);
        chk("fifo_empty_end", fifo_empty, (v.exp_pops == int'(v.cnt)));
    endtask

    // Monitor: sampled mid-cycle, so values shown are what the next edge sees
    always @(negedge clk) begin
        aw_t e;
        w_t  w;
        s_pop  = 1'b0;
        s_bset = 1'b0;
        s_bclr = 1'b0;
        if (!rst) begin
            s_pop  = fifo_ren;
            s_bset = WVALID && WREADY && WLAST;
            s_bclr = BVALID && BREADY;
            if (done) done_cnt++;
            chk("ren_is_handshake", fifo_ren, WVALID && WREADY);
            chk("wvalid_while_empty", WVALID && fifo_empty, 1'b0);
            if (AWVALID && AWREADY) begin
                aw_cnt++;
                checks++;
                if (aw_exp.size() == 0) begin
                    errors++;
                    $display("FAIL aw_unexpected: got AW at 0x%08h expected none", AWADDR);
                end else begin
                    e = aw_exp.pop_front();
                    chk("awaddr", AWADDR, e.addr);
                    chk("awlen",  AWLEN,  e.len);
                end
            end
            if (WVALID && WREADY) begin
                checks++;
                if (w_exp.size() == 0) begin
                    errors++;
                    $display("FAIL w_unexpected: got beat 0x%08h expected none", WDATA);
                end else begin
                    w = w_exp.pop_front();
                    chk("wdata", WDATA, w.data);
                    chk("wlast", WLAST, w.last);
                end
            end
        end
    end

    // FIFO pop and B-channel slave, acting just after each edge
    always @(posedge clk) begin
        #1;
        if (rst) begin
            BVALID = 1'b0;
            BRESP  = 2'b00;
        end else begin
            if (s_pop) begin
                rd_ptr = rd_ptr + 8'd1;
                pop_cnt++;
            end
            if (s_bclr) BVALID = 1'b0;
            if (s_bset) begin
                BVALID = 1'b1;
                BRESP  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
            end
        end
    end

    vec_t vec[5];

    initial begin
        int p0, d0, a0, n;
        vec[0] = '{32'h1000_0000, 16'd5,  32'h0000_00A0, -1, 1, 5,  1'b0, 1'b0};
        vec[1] = '{32'h0000_0000, 16'd40, 32'h0000_0100, -1, 3, 40, 1'b0, 1'b1};
        vec[2] = '{32'h0000_0FF8, 16'd6,  32'h0000_0200, -1, 2, 6,  1'b0, 1'b0};
        vec[3] = '{32'h0000_2000, 16'd32, 32'h0000_0300, 0,  1, 16, 1'b1, 1'b0};
        vec[4] = '{32'h0000_3003, 16'd3,  32'h0000_0400, -1, 1, 3,  1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; base_addr = 32'd0; word_cnt = 16'd0;
        AWREADY = 1'b1; WREADY = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);      chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);        chk("rst_ren", fifo_ren, 1'b0);
        chk("rst_awvalid", AWVALID, 1'b0); chk("rst_wvalid", WVALID, 1'b0);
        chk("rst_wlast", WLAST, 1'b0);    chk("rst_bready", BREADY, 1'b0);
        chk("rst_awaddr", AWADDR, 32'd0); chk("rst_awlen", AWLEN, 4'd0);
        chk("awsize", AWSIZE, 3'b010);    chk("awburst", AWBURST, 2'b01);
        chk("wstrb", WSTRB, 4'hF);        chk("awid", AWID, 4'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_vec(vec[i]);

        // Underrun after beat 2, then WREADY low while beat 3 is presented
        wr_ptr = rd_ptr;
        fifo_fill(32'h0000_0010, 2);
        build_model(32'h0000_4000, 16'd4, 32'h0000_0010, -1);
        p0 = pop_cnt; d0 = done_cnt;
        start_xfer(32'h0000_4000, 16'd4);
        n = 0;
        while (pop_cnt - p0 < 2 && n < 50) begin tick(); n++; end
        chk("underrun_two_pops", 32'(pop_cnt - p0), 32'd2);
        repeat (3) begin
            chk("underrun_wvalid", WVALID, 1'b0);
            chk("underrun_ren", fifo_ren, 1'b0);
            tick();
        end
        WREADY = 1'b0;
        mem[wr_ptr] = 32'h0000_0012; wr_ptr = wr_ptr + 8'd1;
        mem[wr_ptr] = 32'h0000_0013; wr_ptr = wr_ptr + 8'd1;
        repeat (2) begin
            #1;
            chk("stall_wvalid", WVALID, 1'b1);
            chk("stall_ren", fifo_ren, 1'b0);
            chk("stall_wdata", WDATA, 32'h0000_0012);
            chk("stall_wlast", WLAST, 1'b0);
            tick();
        end
        WREADY = 1'b1;
        wait_done(200, d0);
        chk("underrun_pops", 32'(pop_cnt - p0), 32'd4);
        chk("underrun_w_left", 32'(w_exp.size()), 32'd0);

        // Zero-length request
        p0 = pop_cnt; d0 = done_cnt; a0 = aw_cnt;
        start_xfer(32'h0000_5000, 16'd0);
        chk("cnt0_done", done, 1'b1);
        chk("cnt0_awvalid", AWVALID, 1'b0);
        tick();
        chk("cnt0_done_low", done, 1'b0);
        chk("cnt0_busy", busy, 1'b0);
        chk("cnt0_aw", 32'(aw_cnt - a0), 32'd0);
        chk("cnt0_pops", 32'(pop_cnt - p0), 32'd0);
        chk("cnt0_done_count", 32'(done_cnt - d0), 32'd1);

        // Reset while parked in W
        wr_ptr = rd_ptr;
        fifo_fill(32'h0000_0600, 8);
        build_model(32'h0000_6000, 16'd8, 32'h0000_0600, -1);
        WREADY = 1'b0;
        start_xfer(32'h0000_6000, 16'd8);
        n = 0;
        while (!WVALID && n < 20) begin tick(); n++; end
        chk("rstw_in_w", WVALID, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstw_busy", busy, 1'b0);       chk("rstw_wvalid", WVALID, 1'b0);
        chk("rstw_awvalid", AWVALID, 1'b0); chk("rstw_wlast", WLAST, 1'b0);
        chk("rstw_bready", BREADY, 1'b0);   chk("rstw_done", done, 1'b0);
        chk("rstw_awaddr", AWADDR, 32'd0);  chk("rstw_awlen", AWLEN, 4'd0);
        tick();
        rst = 1'b0;
        WREADY = 1'b1;
        aw_exp.delete(); w_exp.delete(); bresp_q.delete();
        tick();
        run_vec(vec[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
